// File: rtl/bus_pkg.sv
// Shared types and address-map constants for the data-bus arbiter and its interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  localparam int NUM_SLAVES  = 5;
  localparam int SLAVE_SEL_W = NUM_SLAVES;
  localparam int PAGE_W      = 24;

  localparam int SEL_RAM  = 0;
  localparam int SEL_GPOA = 1;
  localparam int SEL_GPOB = 2;
  localparam int SEL_GPIC = 3;
  localparam int SEL_GPID = 4;

  // Base pages are compared against address[31:8].
  localparam logic [PAGE_W-1:0] PAGE_RAM  = 24'h0000_00;
  localparam logic [PAGE_W-1:0] PAGE_GPOA = 24'h0000_21;
  localparam logic [PAGE_W-1:0] PAGE_GPOB = 24'h0000_22;
  localparam logic [PAGE_W-1:0] PAGE_GPIC = 24'h0000_23;
  localparam logic [PAGE_W-1:0] PAGE_GPID = 24'h0000_24;

  typedef logic [SLAVE_SEL_W-1:0] slave_sel_t;

  function automatic slave_sel_t decode_sel(input logic [31:0] addr);
    slave_sel_t sel;
    sel           = '0;
    sel[SEL_RAM]  = (addr[31:8] == PAGE_RAM);
    sel[SEL_GPOA] = (addr[31:8] == PAGE_GPOA);
    sel[SEL_GPOB] = (addr[31:8] == PAGE_GPOB);
    sel[SEL_GPIC] = (addr[31:8] == PAGE_GPIC);
    sel[SEL_GPID] = (addr[31:8] == PAGE_GPID);
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester scanning upward, with wrap,
// starting just after the previous winner.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin multi-master front end for the memory-mapped data bus.
// Optional decode-error reporting is enabled with BUS_ARB_DECERR_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS-1:0]   m_we,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]   m_gnt,
  output logic [NUM_MASTERS-1:0]   m_done,
  output logic [31:0]              m_rdata,
  output logic                     m_err,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic                     bus_we,
  input  logic [SLAVE_SEL_W-1:0]   bus_slave_sel,
  input  logic [31:0]              bus_rdata
);

  localparam int               IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_t state, next_state;

  logic [NUM_MASTERS-1:0] win_gnt;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       last_grant, last_grant_d;
  logic [NUM_MASTERS-1:0] owner, owner_d;
  logic [NUM_MASTERS-1:0] gnt_d, done_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_d;
  logic                   we_q, we_d;
  logic                   err_d;
  logic                   dec_err;
  logic [3:0]             wait_cnt, wait_cnt_d;
  logic                   start, capture;
  logic [31:0]            addr_arr  [NUM_MASTERS];
  logic [31:0]            wdata_arr [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i]  = m_addr[32*i +: 32];
      wdata_arr[i] = m_wdata[32*i +: 32];
    end
  end

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req        (m_req),
    .last_grant (last_grant),
    .gnt        (win_gnt),
    .gnt_idx    (win_idx)
  );

  assign start   = (state == ST_IDLE) && (|m_req);
  assign capture = (next_state == ST_DONE);

`ifdef BUS_ARB_DECERR_EN
  logic dec_err_q;

  // The decoder answers combinationally in ADDR, so the strobe is masked in that same cycle.
  always_ff @(posedge clk) begin
    if (!reset)                dec_err_q <= 1'b0;
    else if (state == ST_ADDR) dec_err_q <= ~(|bus_slave_sel);
  end

  assign dec_err = (state == ST_ADDR) ? ~(|bus_slave_sel) : dec_err_q;
  assign bus_we  = we_q & (|bus_slave_sel);
`else
  logic unused_sel;

  assign unused_sel = ^bus_slave_sel;
  assign dec_err    = 1'b0;
  assign bus_we     = we_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (|m_req) next_state = ST_ADDR;
      ST_ADDR: next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (wait_cnt == 4'(WAIT_CYCLES)) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values for every registered output; the address phase holds the latched
  // request until the cycle that hands over to DONE.
  always_comb begin
    gnt_d        = '0;
    done_d       = '0;
    owner_d      = owner;
    last_grant_d = last_grant;
    addr_d       = '0;
    wdata_d      = '0;
    we_d         = 1'b0;
    wait_cnt_d   = '0;
    rdata_d      = m_rdata;
    err_d        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          gnt_d        = win_gnt;
          owner_d      = win_gnt;
          last_grant_d = win_idx;
          addr_d       = addr_arr[win_idx];
          wdata_d      = wdata_arr[win_idx];
          we_d         = m_we[win_idx];
        end
      end
      ST_ADDR, ST_WAIT: begin
        if (!capture) begin
          addr_d     = addr_q;
          wdata_d    = wdata_q;
          wait_cnt_d = wait_cnt + 4'd1;
        end
      end
      default: ;
    endcase
    if (capture) begin
      done_d  = owner;
      rdata_d = dec_err ? 32'h0 : bus_rdata;
      err_d   = dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_gnt      <= '0;
      m_done     <= '0;
      m_rdata    <= '0;
      m_err      <= 1'b0;
      owner      <= '0;
      last_grant <= LAST_RST;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      m_gnt      <= gnt_d;
      m_done     <= done_d;
      m_rdata    <= rdata_d;
      m_err      <= err_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wait_cnt   <= wait_cnt_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule
